// File: rtl/mc_control_if.sv
// mc_control_if: control <-> datapath signal bundle for the multi-cycle MIPS-subset CPU.
// Modports:
//   master - control unit: samples opcode/funct/zero/mem_ready, drives all strobes and selects.
//   slave  - datapath/memory side: the reverse direction.
interface mc_control_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic [4:0] alu_op;
  logic       alu_src_a;
  logic [2:0] alu_src_b;
  logic [1:0] pc_src;
  logic       pc_en;
  logic       ir_write;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output alu_op, alu_src_a, alu_src_b, pc_src, pc_en, ir_write, i_or_d,
           mem_read, mem_write, reg_write, reg_dst, mem_to_reg
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  alu_op, alu_src_a, alu_src_b, pc_src, pc_en, ir_write, i_or_d,
           mem_read, mem_write, reg_write, reg_dst, mem_to_reg
  );
endinterface

// File: rtl/mc_control.sv
// mc_control: multi-cycle control FSM for the MIPS-subset CPU.
// Ports:
//   clk         - clock, rising edge
//   rst_n       - asynchronous active-low reset
//   ctrl        - mc_control_if.master: opcode/funct/zero/mem_ready in, datapath controls out
//   o_halted    - unit is in HALT
//   o_state     - current state (debug)
//   o_instr_cnt - retired-instruction counter, wraps
module mc_control #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  mc_control_if.master     ctrl,
  output logic             o_halted,
  output logic [3:0]       o_state,
  output logic [CNT_W-1:0] o_instr_cnt
);

  localparam logic [3:0] StFetch   = 4'd0;
  localparam logic [3:0] StDecode  = 4'd1;
  localparam logic [3:0] StMemAddr = 4'd2;
  localparam logic [3:0] StMemRd   = 4'd3;
  localparam logic [3:0] StWbMem   = 4'd4;
  localparam logic [3:0] StMemWr   = 4'd5;
  localparam logic [3:0] StExR     = 4'd6;
  localparam logic [3:0] StWbR     = 4'd7;
  localparam logic [3:0] StExI     = 4'd8;
  localparam logic [3:0] StWbI     = 4'd9;
  localparam logic [3:0] StBranch  = 4'd10;
  localparam logic [3:0] StJump    = 4'd11;
  localparam logic [3:0] StHalt    = 4'd12;

  logic [3:0]       r_state;
  logic [CNT_W-1:0] r_instr_cnt;

  logic [3:0] w_next_state;
  logic [4:0] w_alu_op;
  logic       w_alu_src_a;
  logic [2:0] w_alu_src_b;
  logic [1:0] w_pc_src;
  logic       w_pc_en;
  logic       w_ir_write;
  logic       w_i_or_d;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_reg_write;
  logic       w_reg_dst;
  logic       w_mem_to_reg;
  logic       w_halted;
  logic       w_retire;

  always_comb begin
    w_next_state = r_state;
    w_alu_op     = 5'd0;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = 3'd0;
    w_pc_src     = 2'd0;
    w_pc_en      = 1'b0;
    w_ir_write   = 1'b0;
    w_i_or_d     = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_reg_write  = 1'b0;
    w_reg_dst    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_halted     = 1'b0;
    case (r_state)
      StFetch: begin
        w_mem_read  = 1'b1;
        w_alu_src_b = 3'd1;
        w_alu_op    = 5'd1;
        // PC+4 and IR load happen together on the cycle memory delivers
        w_ir_write  = ctrl.mem_ready;
        w_pc_en     = ctrl.mem_ready;
        if (ctrl.mem_ready) w_next_state = StDecode;
      end
      StDecode: begin
        // Speculative branch target into ALUOut
        w_alu_src_b = 3'd3;
        w_alu_op    = 5'd1;
        case (ctrl.opcode)
          6'h00: begin
            case (ctrl.funct)
              6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27: w_next_state = StExR;
              default:                                  w_next_state = StHalt;
            endcase
          end
          6'h08, 6'h0C, 6'h0D, 6'h0E: w_next_state = StExI;
          6'h23, 6'h2B:               w_next_state = StMemAddr;
          6'h04, 6'h05:               w_next_state = StBranch;
          6'h02:                      w_next_state = StJump;
          default:                    w_next_state = StHalt;
        endcase
      end
      StMemAddr: begin
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = 3'd2;
        w_alu_op     = 5'd1;
        w_next_state = (ctrl.opcode == 6'h23) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        w_i_or_d   = 1'b1;
        w_mem_read = 1'b1;
        if (ctrl.mem_ready) w_next_state = StWbMem;
      end
      StWbMem: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
        w_next_state = StFetch;
      end
      StMemWr: begin
        w_i_or_d    = 1'b1;
        w_mem_write = 1'b1;
        if (ctrl.mem_ready) w_next_state = StFetch;
      end
      StExR: begin
        w_alu_src_a = 1'b1;
        case (ctrl.funct)
          6'h20:   w_alu_op = 5'd1;
          6'h22:   w_alu_op = 5'd2;
          6'h24:   w_alu_op = 5'd3;
          6'h25:   w_alu_op = 5'd4;
          6'h26:   w_alu_op = 5'd5;
          6'h27:   w_alu_op = 5'd6;
          default: w_alu_op = 5'd0;
        endcase
        w_next_state = StWbR;
      end
      StWbR: begin
        w_reg_write  = 1'b1;
        w_reg_dst    = 1'b1;
        w_next_state = StFetch;
      end
      StExI: begin
        w_alu_src_a = 1'b1;
        case (ctrl.opcode)
          6'h0C: begin w_alu_src_b = 3'd4; w_alu_op = 5'd3; end
          6'h0D: begin w_alu_src_b = 3'd4; w_alu_op = 5'd4; end
          6'h0E: begin w_alu_src_b = 3'd4; w_alu_op = 5'd5; end
          default: begin w_alu_src_b = 3'd2; w_alu_op = 5'd1; end
        endcase
        w_next_state = StWbI;
      end
      StWbI: begin
        w_reg_write  = 1'b1;
        w_next_state = StFetch;
      end
      StBranch: begin
        w_alu_src_a  = 1'b1;
        w_alu_op     = 5'd2;
        w_pc_src     = 2'd1;
        // opcode 0x04 beq, 0x05 bne
        w_pc_en      = (ctrl.opcode == 6'h05) ? ~ctrl.zero : ctrl.zero;
        w_next_state = StFetch;
      end
      StJump: begin
        w_pc_src     = 2'd2;
        w_pc_en      = 1'b1;
        w_next_state = StFetch;
      end
      StHalt: begin
        w_halted     = 1'b1;
        w_next_state = StHalt;
      end
      default: w_next_state = StHalt;
    endcase
  end

  // Only completing states retire; re-entering FETCH from reset does not.
  always_comb begin
    w_retire = 1'b0;
    if (w_next_state == StFetch) begin
      case (r_state)
        StWbMem, StMemWr, StWbR, StWbI, StBranch, StJump: w_retire = 1'b1;
        default:                                         w_retire = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StFetch;
      r_instr_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_retire) r_instr_cnt <= r_instr_cnt + CNT_W'(1);
    end
  end

  // Strobes are masked during reset so FETCH decode cannot touch PC/IR/memory/regs.
  assign ctrl.pc_en      = w_pc_en     & rst_n;
  assign ctrl.ir_write   = w_ir_write  & rst_n;
  assign ctrl.mem_read   = w_mem_read  & rst_n;
  assign ctrl.mem_write  = w_mem_write & rst_n;
  assign ctrl.reg_write  = w_reg_write & rst_n;
  assign ctrl.alu_op     = w_alu_op;
  assign ctrl.alu_src_a  = w_alu_src_a;
  assign ctrl.alu_src_b  = w_alu_src_b;
  assign ctrl.pc_src     = w_pc_src;
  assign ctrl.i_or_d     = w_i_or_d;
  assign ctrl.reg_dst    = w_reg_dst;
  assign ctrl.mem_to_reg = w_mem_to_reg;

  assign o_halted    = w_halted;
  assign o_state     = r_state;
  assign o_instr_cnt = r_instr_cnt;

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: reset, R-type, lw with memory wait, branches/jump,
// immediates, illegal instructions/HALT and reset during a store.
module tb_mc_control;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        halted;
  logic [3:0]  state;
  logic [31:0] instr_cnt;

  int total = 0;
  int bad = 0;
  int ncyc = 0;
  logic [31:0] exp_cnt = 32'd0;

  mc_control_if bus ();

  mc_control #(.CNT_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ctrl        (bus),
    .o_halted    (halted),
    .o_state     (state),
    .o_instr_cnt (instr_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    ncyc++;
  endtask

  task automatic test_reset();
    bus.mem_ready = 1'b1; bus.opcode = 6'h3F; bus.funct = 6'h00; bus.zero = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    total++; if (state !== 4'd0) begin bad++; $display("FAIL rst_state got=%0d want=0", state); end
    total++; if (instr_cnt !== 32'd0) begin bad++; $display("FAIL rst_cnt got=%0d want=0", instr_cnt); end
    total++; if ({bus.pc_en, bus.ir_write, bus.mem_read, bus.mem_write, bus.reg_write} !== 5'b0)
      begin bad++; $display("FAIL rst_strobes got=%b want=00000",
        {bus.pc_en, bus.ir_write, bus.mem_read, bus.mem_write, bus.reg_write}); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL rst_halted got=%0d want=0", halted); end
    total++; if (bus.alu_op !== 5'd1) begin bad++; $display("FAIL rst_aluop got=%0d want=1", bus.alu_op); end
    rst_n = 1'b1;
    exp_cnt = 32'd0;
    #1;
    total++; if (bus.mem_read !== 1'b1) begin bad++; $display("FAIL rel_memread got=%0d want=1", bus.mem_read); end
  endtask

  task automatic test_add();
    int c0;
    bus.opcode = 6'h00; bus.funct = 6'h20; bus.mem_ready = 1'b1;
    #1;
    c0 = ncyc;
    total++; if ({bus.ir_write, bus.pc_en, bus.alu_src_b, bus.alu_op} !== {1'b1, 1'b1, 3'd1, 5'd1})
      begin bad++; $display("FAIL add_fetch got=%b want=11_001_00001",
        {bus.ir_write, bus.pc_en, bus.alu_src_b, bus.alu_op}); end
    tick();
    total++; if (state !== 4'd1 || bus.alu_src_b !== 3'd3)
      begin bad++; $display("FAIL add_decode state=%0d srcb=%0d want 1/3", state, bus.alu_src_b); end
    tick();
    total++; if (state !== 4'd6 || bus.alu_op !== 5'd1 || bus.alu_src_a !== 1'b1)
      begin bad++; $display("FAIL add_exr state=%0d aluop=%0d want 6/1", state, bus.alu_op); end
    tick();
    total++; if (state !== 4'd7 || bus.reg_write !== 1'b1 || bus.reg_dst !== 1'b1)
      begin bad++; $display("FAIL add_wbr state=%0d rw=%0d rd=%0d want 7/1/1",
        state, bus.reg_write, bus.reg_dst); end
    tick();
    exp_cnt++;
    total++; if (state !== 4'd0 || instr_cnt !== exp_cnt)
      begin bad++; $display("FAIL add_done state=%0d cnt=%0d want 0/%0d", state, instr_cnt, exp_cnt); end
    total++; if (ncyc - c0 !== 4) begin bad++; $display("FAIL add_cycles got=%0d want=4", ncyc - c0); end
  endtask

  task automatic test_sub_funct();
    bus.opcode = 6'h00; bus.funct = 6'h27; bus.mem_ready = 1'b1;
    tick(); tick();
    total++; if (state !== 4'd6 || bus.alu_op !== 5'd6)
      begin bad++; $display("FAIL nor_exr state=%0d aluop=%0d want 6/6", state, bus.alu_op); end
    tick(); tick();
    exp_cnt++;
  endtask

  task automatic test_lw_wait();
    int c0;
    bus.opcode = 6'h23; bus.mem_ready = 1'b0;
    #1;
    total++; if (bus.ir_write !== 1'b0 || bus.pc_en !== 1'b0)
      begin bad++; $display("FAIL fetch_wait_strobe ir=%0d pc=%0d want 0/0", bus.ir_write, bus.pc_en); end
    tick();
    total++; if (state !== 4'd0) begin bad++; $display("FAIL fetch_wait_state got=%0d want=0", state); end
    bus.mem_ready = 1'b1;
    c0 = ncyc;
    tick();
    tick();
    total++; if (state !== 4'd2 || bus.alu_src_b !== 3'd2 || bus.alu_src_a !== 1'b1)
      begin bad++; $display("FAIL lw_addr state=%0d srcb=%0d want 2/2", state, bus.alu_src_b); end
    bus.mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      total++; if (state !== 4'd3 || bus.mem_read !== 1'b1 || bus.i_or_d !== 1'b1)
        begin bad++; $display("FAIL lw_wait%0d state=%0d rd=%0d iod=%0d want 3/1/1",
          i, state, bus.mem_read, bus.i_or_d); end
      tick();
    end
    bus.mem_ready = 1'b1;
    #1;
    total++; if (state !== 4'd3) begin bad++; $display("FAIL lw_memrd_last got=%0d want=3", state); end
    tick();
    total++; if (state !== 4'd4 || bus.mem_to_reg !== 1'b1 || bus.reg_write !== 1'b1 || bus.reg_dst !== 1'b0)
      begin bad++; $display("FAIL lw_wb state=%0d m2r=%0d rw=%0d want 4/1/1",
        state, bus.mem_to_reg, bus.reg_write); end
    tick();
    exp_cnt++;
    total++; if (ncyc - c0 !== 8 || state !== 4'd0 || instr_cnt !== exp_cnt)
      begin bad++; $display("FAIL lw_done cycles=%0d state=%0d cnt=%0d want 8/0/%0d",
        ncyc - c0, state, instr_cnt, exp_cnt); end
  endtask

  task automatic test_branch();
    bus.opcode = 6'h04; bus.zero = 1'b1; bus.mem_ready = 1'b1;
    tick(); tick();
    total++; if (state !== 4'd10 || bus.pc_en !== 1'b1 || bus.pc_src !== 2'd1 || bus.alu_op !== 5'd2)
      begin bad++; $display("FAIL beq_taken state=%0d pcen=%0d pcsrc=%0d want 10/1/1",
        state, bus.pc_en, bus.pc_src); end
    tick();
    exp_cnt++;
    total++; if (state !== 4'd0 || instr_cnt !== exp_cnt)
      begin bad++; $display("FAIL beq_done state=%0d cnt=%0d want 0/%0d", state, instr_cnt, exp_cnt); end
    bus.opcode = 6'h05; bus.zero = 1'b1;
    tick(); tick();
    total++; if (state !== 4'd10 || bus.pc_en !== 1'b0)
      begin bad++; $display("FAIL bne_nottaken state=%0d pcen=%0d want 10/0", state, bus.pc_en); end
    bus.zero = 1'b0;
    #1;
    total++; if (bus.pc_en !== 1'b1) begin bad++; $display("FAIL bne_taken got=%0d want=1", bus.pc_en); end
    tick();
    exp_cnt++;
    bus.opcode = 6'h02;
    tick(); tick();
    total++; if (state !== 4'd11 || bus.pc_src !== 2'd2 || bus.pc_en !== 1'b1)
      begin bad++; $display("FAIL jump state=%0d pcsrc=%0d pcen=%0d want 11/2/1",
        state, bus.pc_src, bus.pc_en); end
    tick();
    exp_cnt++;
    total++; if (state !== 4'd0 || instr_cnt !== exp_cnt)
      begin bad++; $display("FAIL jump_done state=%0d cnt=%0d want 0/%0d", state, instr_cnt, exp_cnt); end
  endtask

  task automatic test_imm();
    logic [5:0] ops  [3] = '{6'h0D, 6'h0E, 6'h08};
    logic [2:0] srcb [3] = '{3'd4, 3'd4, 3'd2};
    logic [4:0] aop  [3] = '{5'd4, 5'd5, 5'd1};
    for (int i = 0; i < 3; i++) begin
      bus.opcode = ops[i]; bus.mem_ready = 1'b1;
      tick(); tick();
      total++; if (state !== 4'd8 || bus.alu_src_b !== srcb[i] || bus.alu_op !== aop[i])
        begin bad++; $display("FAIL imm_ex%0d state=%0d srcb=%0d aluop=%0d want 8/%0d/%0d",
          i, state, bus.alu_src_b, bus.alu_op, srcb[i], aop[i]); end
      tick();
      total++; if (state !== 4'd9 || bus.reg_write !== 1'b1 || bus.reg_dst !== 1'b0)
        begin bad++; $display("FAIL imm_wb%0d state=%0d rw=%0d rd=%0d want 9/1/0",
          i, state, bus.reg_write, bus.reg_dst); end
      tick();
      exp_cnt++;
    end
    total++; if (instr_cnt !== exp_cnt)
      begin bad++; $display("FAIL imm_cnt got=%0d want=%0d", instr_cnt, exp_cnt); end
  endtask

  task automatic test_halt();
    logic [11:0] bad_ins [2] = '{{6'h3F, 6'h20}, {6'h00, 6'h00}};
    for (int i = 0; i < 2; i++) begin
      bus.opcode = bad_ins[i][11:6]; bus.funct = bad_ins[i][5:0]; bus.mem_ready = 1'b1;
      tick(); tick();
      total++; if (state !== 4'd12 || halted !== 1'b1)
        begin bad++; $display("FAIL halt%0d state=%0d halted=%0d want 12/1", i, state, halted); end
      tick(); tick();
      total++; if (state !== 4'd12 || instr_cnt !== exp_cnt || bus.alu_op !== 5'd0 ||
                   {bus.pc_en, bus.ir_write, bus.mem_read, bus.mem_write, bus.reg_write} !== 5'b0)
        begin bad++; $display("FAIL halt_hold%0d state=%0d cnt=%0d aluop=%0d want 12/%0d/0",
          i, state, instr_cnt, bus.alu_op, exp_cnt); end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      exp_cnt = 32'd0;
      total++; if (state !== 4'd0 || instr_cnt !== 32'd0 || halted !== 1'b0)
        begin bad++; $display("FAIL halt_reset%0d state=%0d cnt=%0d want 0/0", i, state, instr_cnt); end
    end
  endtask

  task automatic test_reset_memwr();
    bus.opcode = 6'h2B; bus.mem_ready = 1'b1;
    tick(); tick();
    bus.mem_ready = 1'b0;
    tick();
    total++; if (state !== 4'd5 || bus.mem_write !== 1'b1 || bus.i_or_d !== 1'b1)
      begin bad++; $display("FAIL sw_wr state=%0d wr=%0d want 5/1", state, bus.mem_write); end
    #3;
    rst_n = 1'b0;
    #1;
    total++; if (state !== 4'd0 || bus.mem_write !== 1'b0 || instr_cnt !== 32'd0)
      begin bad++; $display("FAIL sw_rst state=%0d wr=%0d cnt=%0d want 0/0/0",
        state, bus.mem_write, instr_cnt); end
    tick();
    bus.mem_ready = 1'b1;
    rst_n = 1'b1;
    exp_cnt = 32'd0;
    test_add();
  endtask

  task automatic test_back_to_back();
    int c0;
    bus.opcode = 6'h2B; bus.mem_ready = 1'b1;
    c0 = ncyc;
    tick(); tick(); tick(); tick();
    exp_cnt++;
    total++; if (ncyc - c0 !== 4 || state !== 4'd0 || instr_cnt !== exp_cnt)
      begin bad++; $display("FAIL sw_fast cycles=%0d state=%0d cnt=%0d want 4/0/%0d",
        ncyc - c0, state, instr_cnt, exp_cnt); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_funct();
    test_lw_wait();
    test_branch();
    test_imm();
    test_back_to_back();
    test_halt();
    test_reset_memwr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mc_control.md
# mc_control

Multi-cycle control unit for the course MIPS-subset CPU. It decodes the latched instruction's opcode/funct, sequences each instruction through a state machine, and drives the datapath muxes, memory strobes, register-file write and `alu_op`. `alu_op` is the command input of the datapath ALU: 0 zero, 1 add, 2 sub, 3 and, 4 or, 5 xor, 6 nor. Memory accesses use a ready handshake, so the unit waits on slow memory.

## Interface
- `CNT_W`, 32, width of the retired-instruction counter
- `clk` in 1: the single clock; all state changes on its rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `opcode` in 6: IR[31:26], held stable by the IR outside FETCH
- `funct` in 6: IR[5:0]
- `zero` in 1: ALU result == 0, from the datapath
- `mem_ready` in 1: memory access completes this cycle
- `alu_op` out 5: ALU command, encoding as above
- `alu_src_a` out 1: 0 selects PC, 1 selects reg A
- `alu_src_b` out 3: 0 B, 1 const 4, 2 sext imm, 3 sext imm<<2, 4 zext imm
- `pc_src` out 2: 0 ALU result, 1 ALUOut, 2 jump target
- `pc_en` out 1: PC load
- `ir_write` out 1: IR load
- `i_or_d` out 1: memory address select, 0 PC, 1 ALUOut
- `mem_read` out 1: memory read strobe
- `mem_write` out 1: memory write strobe
- `reg_write` out 1: register-file write
- `reg_dst` out 1: destination select, 0 rt, 1 rd
- `mem_to_reg` out 1: write-back source, 1 selects MDR
- `halted` out 1: unit is in HALT
- `state` out 4: current state, for debug
- `instr_cnt` out CNT_W: count of retired instructions

## Operation
Outputs are Moore-decoded from `state`, except `pc_en` and `ir_write`, which are Mealy as noted. Any output not listed for a state is 0, including `alu_op`.

States and their outputs:
- 0 FETCH: `i_or_d`=0, `mem_read`=1, `alu_src_a`=0, `alu_src_b`=1, `alu_op`=1, `pc_src`=0.
  - `ir_write`=`pc_en`=`mem_ready`.
  - Leaves to DECODE when `mem_ready`=1; otherwise stays.
- 1 DECODE: `alu_src_a`=0, `alu_src_b`=3, `alu_op`=1 (branch target into ALUOut). Next state by opcode:
  - 0x00 with funct in {0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x26 xor, 0x27 nor} → EX_R.
  - 0x08, 0x0C, 0x0D, 0x0E → EX_I.
  - 0x23, 0x2B → MEM_ADDR.
  - 0x04, 0x05 → BRANCH.
  - 0x02 → JUMP.
  - Anything else, including opcode 0 with an unlisted funct → HALT.
- 2 MEM_ADDR: `alu_src_a`=1, `alu_src_b`=2, `alu_op`=1. Next is MEM_RD for 0x23, MEM_WR for 0x2B.
- 3 MEM_RD: `i_or_d`=1, `mem_read`=1. Waits for `mem_ready`, then WB_MEM.
- 4 WB_MEM: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=1. Next FETCH.
- 5 MEM_WR: `i_or_d`=1, `mem_write`=1. Waits for `mem_ready`, then FETCH.
- 6 EX_R: `alu_src_a`=1, `alu_src_b`=0. `alu_op` from funct: 0x20→1, 0x22→2, 0x24→3, 0x25→4, 0x26→5, 0x27→6. Next WB_R.
- 7 WB_R: `reg_write`=1, `reg_dst`=1. Next FETCH.
- 8 EX_I: `alu_src_a`=1. Next WB_I.
  - addi: `alu_src_b`=2, `alu_op`=1.
  - andi/ori/xori: `alu_src_b`=4, `alu_op`=3/4/5.
- 9 WB_I: `reg_write`=1, `reg_dst`=0. Next FETCH.
- 10 BRANCH: `alu_src_a`=1, `alu_src_b`=0, `alu_op`=2, `pc_src`=1.
  - `pc_en`=`zero` for beq, `pc_en`=~`zero` for bne.
  - Next FETCH.
- 11 JUMP: `pc_src`=2, `pc_en`=1. Next FETCH.
- 12 HALT: `halted`=1, all strobes 0. Stays until reset.
- Encodings 13–15 are unreachable and go to HALT.

Retired-instruction counter:
- `instr_cnt` increments by 1 on each transition into FETCH from WB_MEM, MEM_WR, WB_R, WB_I, BRANCH or JUMP.
- It wraps modulo 2^CNT_W.

## Timing
- Reset: `rst_n`=0 asynchronously forces `state`=FETCH (0) and `instr_cnt`=0.
  - While `rst_n`=0, `pc_en`, `ir_write`, `mem_read`, `mem_write` and `reg_write` are forced to 0.
  - `halted`=0 and `alu_op`=1 (FETCH decode).
- Reset mid-instruction abandons the instruction and does not count it.
- Cycles per instruction with zero wait: R/I-type 4, lw 5, sw 4, branch 3, jump 3.
- Each wait cycle with `mem_ready`=0 in FETCH, MEM_RD or MEM_WR adds 1 cycle. All outputs are held constant during the wait.
- `opcode`, `funct` and `zero` are sampled only in the states that use them; their values in FETCH are ignored.
- The `instr_cnt` increment is visible in the cycle after the final state of the instruction.

## Test plan
- Reset, then add (opcode 0, funct 0x20) with `mem_ready`=1 → states 0,1,6,7,0. `alu_op`=1 in EX_R; `reg_write`=1 and `reg_dst`=1 in WB_R; `instr_cnt`=1.
- lw (0x23) with `mem_ready` low for 3 cycles in MEM_RD → MEM_RD lasts 4 cycles with `mem_read`=1, `i_or_d`=1 held; 8 cycles total; WB_MEM has `mem_to_reg`=1.
- beq with `zero`=1 → `pc_en`=1, `pc_src`=1 in BRANCH. bne with `zero`=1 → `pc_en`=0. Each takes 3 cycles.
- ori (0x0D) then xori (0x0E) → `alu_src_b`=4 with `alu_op`=4, then 5. addi (0x08) → `alu_src_b`=2, `alu_op`=1.
- Illegal opcode 0x3F, and opcode 0 with funct 0x00 → HALT in the cycle after DECODE. `halted`=1, strobes 0, `instr_cnt` unchanged. Stays in HALT until `rst_n`=0.
- `rst_n` pulsed low mid-cycle during MEM_WR → immediately `state`=0, `mem_write`=0, `instr_cnt`=0. After release, the unit fetches normally.
